// File: rtl/filler_pkg.sv
// Shared geometry defaults and FSM state type for the framebuffer filler.
package filler_pkg;

  localparam int H_RES_DEFAULT = 160;
  localparam int V_RES_DEFAULT = 120;
  localparam int FB_DEPTH      = H_RES_DEFAULT * V_RES_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/filler_pattern.sv
// Combinational pixel pattern: checkerboard, plus a one-pixel frame border
// when FILLER_BORDER_EN is defined.
module filler_pattern
  import filler_pkg::*;
#(
  parameter int H_RES   = H_RES_DEFAULT,
  parameter int V_RES   = V_RES_DEFAULT,
  parameter int SQ_LOG2 = 3,
  parameter int XW      = $clog2(H_RES_DEFAULT),
  parameter int YW      = $clog2(V_RES_DEFAULT)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic          pixel
);

  logic square;

  assign square = x[SQ_LOG2] ^ y[SQ_LOG2];

`ifdef FILLER_BORDER_EN
  logic border;

  assign border = (x == '0) || (x == XW'(H_RES - 1)) ||
                  (y == '0) || (y == YW'(V_RES - 1));
  assign pixel  = square | border;
`else
  // Only one bit of each coordinate feeds the plain checkerboard.
  localparam int unused_res = H_RES + V_RES;
  logic unused_coords;

  assign unused_coords = ^{x, y};
  assign pixel         = square;
`endif

endmodule

// File: rtl/filler.sv
// Fills a monochrome framebuffer once per reset with a checkerboard, one write
// per clock. Optional border via FILLER_BORDER_EN (see filler_pattern).
module filler
  import filler_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(FB_DEPTH),
  parameter int H_RES      = H_RES_DEFAULT,
  parameter int V_RES      = V_RES_DEFAULT,
  parameter int SQ_LOG2    = 3
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  pixel
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  state_t                state, state_next;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  issue;
  logic                  last_px;
  logic                  pat_pixel;

  assign last_px = (x == X_LAST) && (y == Y_LAST);

  filler_pattern #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .SQ_LOG2(SQ_LOG2),
    .XW     (XW),
    .YW     (YW)
  ) u_pattern (
    .x    (x),
    .y    (y),
    .pixel(pat_pixel)
  );

  // reset_n is active-high despite its name.
  always_ff @(posedge clk_25) begin
    if (reset_n) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Pixel 0 is issued on the same edge that leaves IDLE, so write k lands k+1 clocks after release.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        issue      = 1'b1;
        state_next = last_px ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        issue = 1'b1;
        if (last_px) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (reset_n) begin
      x          <= '0;
      y          <= '0;
      addr_cnt   <= '0;
      we         <= 1'b0;
      write_addr <= '0;
      pixel      <= 1'b0;
    end else begin
      we         <= issue;
      write_addr <= issue ? addr_cnt : '0;
      pixel      <= issue ? pat_pixel : 1'b0;
      if (issue) begin
        addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_filler.sv
// Self-checking bench for filler: scoreboard of every expected write plus a
// table of spot-checked addresses; covers reset, full fill, and mid-fill abort.
module tb_filler;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int FB       = H_RES * V_RES;
  localparam int AW       = 15;
  localparam int SQ_LOG2  = 3;

  logic          clk_25 = 1'b0;
  logic          reset_n;
  logic          we;
  logic [AW-1:0] write_addr;
  logic          pixel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int addr;
    bit pix;
  } wr_t;

  typedef struct {
    int addr;
    bit exp_pix;
  } spot_t;

  wr_t   sb_q[$];
  spot_t spot[$];
  int    spot_hits;

  filler #(
    .ADDR_WIDTH(AW),
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .SQ_LOG2   (SQ_LOG2)
  ) dut (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .we        (we),
    .write_addr(write_addr),
    .pixel     (pixel)
  );

  always #20 clk_25 = ~clk_25;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_pixel(input int k);
    int x, y;
    bit p;
    x = k % H_RES;
    y = k / H_RES;
    p = bit'((x >> SQ_LOG2) & 1) ^ bit'((y >> SQ_LOG2) & 1);
`ifdef FILLER_BORDER_EN
    if (x == 0 || x == H_RES - 1 || y == 0 || y == V_RES - 1) p = 1'b1;
`endif
    return p;
  endfunction

  // Called at a negedge; releases reset and follows the fill. With abort_addr >= 0
  // it pulses reset for one clock once that address is seen.
  task automatic fill_run(input int abort_addr, output bit aborted);
    int  nwrites;
    bit  broke;
    wr_t e;
    aborted   = 1'b0;
    broke     = 1'b0;
    nwrites   = 0;
    spot_hits = 0;
    sb_q.delete();
    for (int k = 0; k < FB; k++) sb_q.push_back('{addr: k, pix: model_pixel(k)});
    reset_n = 1'b0;
    for (int c = 0; c < FB + 10 && sb_q.size() != 0 && !aborted && !broke; c++) begin
      @(negedge clk_25);
      if (we !== 1'b1) begin
        chk("fill_we", 32'(we), 32'd1);
        broke = 1'b1;
      end else begin
        e = sb_q.pop_front();
        nwrites++;
        chk("fill_addr", 32'(write_addr), 32'(e.addr));
        chk("fill_pixel", 32'(pixel), 32'(e.pix));
        for (int i = 0; i < spot.size(); i++) begin
          if (int'(write_addr) == spot[i].addr) begin
            spot_hits++;
            chk($sformatf("spot_pixel@%0d", spot[i].addr), 32'(pixel), 32'(spot[i].exp_pix));
          end
        end
        if (abort_addr >= 0 && int'(write_addr) == abort_addr) begin
          reset_n = 1'b1;
          @(negedge clk_25);
          chk("abort_we", 32'(we), 32'd0);
          chk("abort_addr", 32'(write_addr), 32'd0);
          chk("abort_pixel", 32'(pixel), 32'd0);
          aborted = 1'b1;
        end
      end
    end
    if (!aborted) begin
      chk("fill_writes", 32'(nwrites), 32'(FB));
      chk("fill_queue_left", 32'(sb_q.size()), 32'd0);
      chk("spot_hits", 32'(spot_hits), 32'(spot.size()));
      for (int c = 0; c < 100; c++) begin
        @(negedge clk_25);
        chk("done_we", 32'(we), 32'd0);
        if (c == 0) begin
          chk("done_addr", 32'(write_addr), 32'd0);
          chk("done_pixel", 32'(pixel), 32'd0);
        end
      end
    end
  endtask

  initial begin
    bit ab;
`ifdef FILLER_BORDER_EN
    spot.push_back('{addr: 0,     exp_pix: 1'b1});
    spot.push_back('{addr: 159,   exp_pix: 1'b1});
    spot.push_back('{addr: 160,   exp_pix: 1'b1});
    spot.push_back('{addr: 161,   exp_pix: 1'b0});
    spot.push_back('{addr: 19199, exp_pix: 1'b1});
    spot.push_back('{addr: 1288,  exp_pix: 1'b0});
`else
    spot.push_back('{addr: 0,     exp_pix: 1'b0});
    spot.push_back('{addr: 1,     exp_pix: 1'b0});
    spot.push_back('{addr: 2,     exp_pix: 1'b0});
    spot.push_back('{addr: 8,     exp_pix: 1'b1});
    spot.push_back('{addr: 159,   exp_pix: 1'b1});
    spot.push_back('{addr: 160,   exp_pix: 1'b0});
    spot.push_back('{addr: 161,   exp_pix: 1'b0});
    spot.push_back('{addr: 1288,  exp_pix: 1'b0});
    spot.push_back('{addr: 19199, exp_pix: 1'b1});
`endif

    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_25);
      chk("reset_we", 32'(we), 32'd0);
      chk("reset_addr", 32'(write_addr), 32'd0);
      chk("reset_pixel", 32'(pixel), 32'd0);
    end

    fill_run(-1, ab);

    reset_n = 1'b1;
    @(negedge clk_25);
    chk("rearm_we", 32'(we), 32'd0);
    fill_run(5000, ab);
    chk("abort_seen", 32'(ab), 32'd1);
    fill_run(-1, ab);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
